// File: rtl/bsg_manycore_barrier_ctrl.sv
// Per-tile barrier sequencer: drives the local sense bit into bsg_barrier and pulses done on global match.
// Optional WAIT-cycle timeout diagnostic is built when BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN is defined.
module bsg_manycore_barrier_ctrl #(
  parameter  int barrier_dirs_p     = 5,
  parameter  int timeout_cycles_p   = 1024,
  localparam int barrier_lg_dirs_lp = ($clog2(barrier_dirs_p+1) < 1) ? 1 : $clog2(barrier_dirs_p+1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic                          cfg_v_i,
  input  logic [barrier_dirs_p-1:0]     cfg_src_i,
  input  logic [barrier_lg_dirs_lp-1:0] cfg_dest_i,
  output logic                          cfg_yumi_o,

  input  logic                          join_v_i,
  output logic                          join_ready_o,
  output logic                          done_v_o,
  output logic                          busy_o,
  output logic                          timeout_o,

  output logic                          barrier_data_o,
  input  logic                          barrier_data_i,
  output logic [barrier_dirs_p-1:0]     barrier_src_r_o,
  output logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                        state_q;
  logic                          sense_q;
  logic [barrier_dirs_p-1:0]     src_q;
  logic [barrier_lg_dirs_lp-1:0] dest_q;
  logic                          idle;
  logic                          join_accept;

  // Config owns the IDLE cycle it is presented in; a simultaneous join waits one cycle.
  assign idle         = (state_q == IDLE);
  assign cfg_yumi_o   = idle & cfg_v_i;
  assign join_ready_o = idle & ~cfg_v_i;
  assign join_accept  = join_v_i & join_ready_o;

  // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sense_q <= 1'b0;
      src_q   <= '0;
      dest_q  <= '0;
    end else begin
      if (cfg_yumi_o) begin
        src_q  <= cfg_src_i;
        dest_q <= cfg_dest_i;
      end
      unique case (state_q)
        IDLE: if (join_accept) begin
          sense_q <= ~sense_q;
          state_q <= WAIT;
        end
        WAIT: if (barrier_data_i == sense_q) state_q <= DONE;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign barrier_data_o   = sense_q;
  assign busy_o           = ~idle;
  assign done_v_o         = (state_q == DONE);
  assign barrier_src_r_o  = src_q;
  assign barrier_dest_r_o = dest_q;

`ifdef BSG_MANYCORE_BARRIER_CTRL_TIMEOUT_EN
  localparam int timeout_width_lp = ($clog2(timeout_cycles_p+1) < 1) ? 1 : $clog2(timeout_cycles_p+1);
  localparam logic [timeout_width_lp-1:0] timeout_max_lp = timeout_width_lp'(timeout_cycles_p);

  logic [timeout_width_lp-1:0] cnt_q, cnt_d;
  logic                        timeout_q;

  // Saturating WAIT-cycle count; the flag is diagnostic only and never aborts WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != timeout_max_lp) cnt_d = cnt_q + timeout_width_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (join_accept) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_d;
      if (cnt_d == timeout_max_lp) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
